// File: rtl/uart_rx_retx.sv
// Serial receiver for the 32-bit retransmission UART link: start/data/parity/stop deframing, NACK on error.
// Parity checking is enabled by defining UART_RX_PARITY_EN; otherwise the parity bit time is consumed and ignored.
module uart_rx_retx #(
  parameter int size  = 32,
  parameter int ERR_W = 8
) (
  input  logic             CLK_Baudin,
  input  logic             RstRx_n,
  input  logic             RxSerial,
  output logic [size-1:0]  DataOut,
  output logic             DoneRx,
  output logic             Flag,
  output logic             FrameErr,
  output logic [ERR_W-1:0] ErrCount
);

  localparam int CNT_W = (size > 1) ? $clog2(size) : 1;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [size-1:0]   shift_reg;
  logic              parity_err;

`ifdef UART_RX_PARITY_EN
  // Running XOR of data bits and P; nonzero at STOP means odd parity was received.
  logic par_acc;

  always_ff @(posedge CLK_Baudin or negedge RstRx_n) begin
    if (!RstRx_n) begin
      par_acc <= 1'b0;
    end else begin
      case (state)
        IDLE:         par_acc <= 1'b0;
        DATA, PARITY: par_acc <= par_acc ^ RxSerial;
        default:      par_acc <= par_acc;
      endcase
    end
  end

  assign parity_err = par_acc;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge CLK_Baudin or negedge RstRx_n) begin
    if (!RstRx_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      DataOut   <= '0;
      DoneRx    <= 1'b0;
      Flag      <= 1'b0;
      FrameErr  <= 1'b0;
      ErrCount  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge values
      // and the default pulse clears below are overridden cleanly by later assignments.
      DoneRx   <= 1'b0;
      Flag     <= 1'b0;
      FrameErr <= 1'b0;

      case (state)
        IDLE: begin
          if (!RxSerial) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end

        DATA: begin
          shift_reg[bit_cnt] <= RxSerial;
          if (bit_cnt == CNT_W'(size - 1)) begin
            state   <= PARITY;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        PARITY: state <= STOP;

        STOP: begin
          if (RxSerial) begin
            state <= IDLE;
            if (parity_err) begin
              Flag <= 1'b1;
              if (!(&ErrCount)) ErrCount <= ErrCount + ERR_W'(1);
            end else begin
              DataOut <= shift_reg;
              DoneRx  <= 1'b1;
            end
          end else begin
            // Bad stop bit: wait for the line to return high before hunting for a start bit.
            state    <= WAIT_IDLE;
            Flag     <= 1'b1;
            FrameErr <= 1'b1;
            if (!(&ErrCount)) ErrCount <= ErrCount + ERR_W'(1);
          end
        end

        WAIT_IDLE: begin
          if (RxSerial) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_retx.sv
// Self-checking bench for uart_rx_retx: table of directed frames plus hand-written corner sequences.
// Expectations follow the build: UART_RX_PARITY_EN defined or not.
module tb_uart_rx_retx;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        CLK_Baudin;
  logic        RstRx_n;
  logic        RxSerial;
  logic [31:0] DataOut;
  logic        DoneRx;
  logic        Flag;
  logic        FrameErr;
  logic [7:0]  ErrCount;

  int n_pass  = 0;
  int n_total = 0;

  uart_rx_retx #(.size(32), .ERR_W(8)) dut (
    .CLK_Baudin (CLK_Baudin),
    .RstRx_n    (RstRx_n),
    .RxSerial   (RxSerial),
    .DataOut    (DataOut),
    .DoneRx     (DoneRx),
    .Flag       (Flag),
    .FrameErr   (FrameErr),
    .ErrCount   (ErrCount)
  );

  initial CLK_Baudin = 1'b0;
  always #5 CLK_Baudin = ~CLK_Baudin;

  typedef struct {
    logic [31:0] data;
    logic        p;
    logic        stop;
    logic        exp_done;
    logic        exp_flag;
    logic        exp_ferr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic check_outs(input string tag, input logic done, input logic flag, input logic ferr,
                            input logic [31:0] data, input logic [7:0] errc);
    check({tag, ".DoneRx"},   32'(DoneRx),   32'(done));
    check({tag, ".Flag"},     32'(Flag),     32'(flag));
    check({tag, ".FrameErr"}, 32'(FrameErr), 32'(ferr));
    check({tag, ".DataOut"},  DataOut,       data);
    check({tag, ".ErrCount"}, 32'(ErrCount), 32'(errc));
  endtask

  // Called at a negedge; each bit is driven half a period before the sampling edge.
  // Returns at the negedge just after E34, when the evaluation outputs are visible.
  task automatic send_frame(input logic [31:0] d, input logic p, input logic s);
    RxSerial = 1'b0;
    @(negedge CLK_Baudin);
    for (int i = 0; i < 32; i++) begin
      RxSerial = d[i];
      @(negedge CLK_Baudin);
    end
    RxSerial = p;
    @(negedge CLK_Baudin);
    RxSerial = s;
    @(negedge CLK_Baudin);
  endtask

  task automatic idle(input int n);
    RxSerial = 1'b1;
    repeat (n) @(negedge CLK_Baudin);
  endtask

  logic [7:0]  exp_err;
  logic [31:0] exp_data;

  initial begin
    // Parity reference: A5A5A5A5 and DEADBEEF have even weight, 12345678/00000001/80000000 odd.
    vecs[0] = '{32'hA5A5A5A5, 1'b0, 1'b1, 1'b1,    1'b0,   1'b0, 32'hA5A5A5A5};
    vecs[1] = '{32'hDEADBEEF, 1'b1, 1'b1, !PAR_EN, PAR_EN, 1'b0, PAR_EN ? 32'hA5A5A5A5 : 32'hDEADBEEF};
    vecs[2] = '{32'hDEADBEEF, 1'b0, 1'b1, 1'b1,    1'b0,   1'b0, 32'hDEADBEEF};
    vecs[3] = '{32'h12345678, 1'b1, 1'b1, 1'b1,    1'b0,   1'b0, 32'h12345678};
    vecs[4] = '{32'h12345678, 1'b0, 1'b1, !PAR_EN, PAR_EN, 1'b0, 32'h12345678};
    vecs[5] = '{32'hA5A5A5A5, 1'b0, 1'b0, 1'b0,    1'b1,   1'b1, 32'h12345678};
    vecs[6] = '{32'h00000000, 1'b0, 1'b1, 1'b1,    1'b0,   1'b0, 32'h00000000};
    vecs[7] = '{32'hFFFFFFFF, 1'b0, 1'b1, 1'b1,    1'b0,   1'b0, 32'hFFFFFFFF};
    vecs[8] = '{32'h00000001, 1'b1, 1'b1, 1'b1,    1'b0,   1'b0, 32'h00000001};
    vecs[9] = '{32'h80000000, 1'b0, 1'b1, !PAR_EN, PAR_EN, 1'b0, PAR_EN ? 32'h00000001 : 32'h80000000};

    RstRx_n  = 1'b0;
    RxSerial = 1'b1;
    #200;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 32'h0, 8'd0);
    @(negedge CLK_Baudin);
    RstRx_n = 1'b1;

    // Table: each frame, check the E34 pulse, then idle and confirm the pulse lasted one cycle.
    exp_err = 8'd0;
    for (int v = 0; v < 10; v++) begin
      send_frame(vecs[v].data, vecs[v].p, vecs[v].stop);
      if (vecs[v].exp_flag && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      check_outs($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_flag,
                 vecs[v].exp_ferr, vecs[v].exp_data, exp_err);
      idle(1);
      check_outs($sformatf("vec%0d_after", v), 1'b0, 1'b0, 1'b0, vecs[v].exp_data, exp_err);
      idle(1);
    end
    exp_data = vecs[9].exp_data;

    // Back-to-back: second start bit sampled at E35 with no idle gap.
    send_frame(32'h12345678, 1'b1, 1'b1);
    check_outs("b2b_first", 1'b1, 1'b0, 1'b0, 32'h12345678, exp_err);
    send_frame(32'hA5A5A5A5, 1'b0, 1'b1);
    check_outs("b2b_second", 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, exp_err);
    idle(2);

    // Framing error, line held low: no start detection until a 1 is seen.
    send_frame(32'hA5A5A5A5, 1'b0, 1'b0);
    exp_err = exp_err + 8'd1;
    check_outs("ferr", 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, exp_err);
    RxSerial = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK_Baudin);
      check($sformatf("ferr_low%0d.DoneRx", c), 32'(DoneRx), 32'd0);
      check($sformatf("ferr_low%0d.Flag", c),   32'(Flag),   32'd0);
    end
    idle(1);
    send_frame(32'h12345678, 1'b1, 1'b1);
    check_outs("ferr_recover", 1'b1, 1'b0, 1'b0, 32'h12345678, exp_err);
    idle(2);

    // Reset asserted while data bit 10 is on the line.
    RxSerial = 1'b0;
    @(negedge CLK_Baudin);
    for (int i = 0; i < 10; i++) begin
      RxSerial = exp_data[0] ^ 32'hDEADBEEF >> i;
      RxSerial = 32'(32'hDEADBEEF >> i) & 32'h1;
      @(negedge CLK_Baudin);
    end
    RxSerial = 1'b1;
    #2 RstRx_n = 1'b0;
    #1 check_outs("midreset", 1'b0, 1'b0, 1'b0, 32'h0, 8'd0);
    @(negedge CLK_Baudin);
    RstRx_n = 1'b1;
    idle(1);
    send_frame(32'h12345678, 1'b1, 1'b1);
    check_outs("post_reset", 1'b1, 1'b0, 1'b0, 32'h12345678, 8'd0);
    idle(1);

    // Error counter saturation.
    exp_err = 8'd0;
    for (int k = 1; k <= 258; k++) begin
      send_frame(32'hA5A5A5A5, 1'b0, 1'b0);
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      idle(1);
      if (k == 254 || k == 255 || k == 258)
        check($sformatf("sat%0d.ErrCount", k), 32'(ErrCount), 32'(exp_err));
    end
    check("sat_final.ErrCount", 32'(ErrCount), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
